// File: rtl/rec_bank_tlb_mp.sv
// Multi-page rec-bank pointer table: cover FSM rewrites a CU footprint with a bank free in all pages.
// pre/ec lookups are 1-cycle registered; cover takes len+1 cycles and holds cover_ready_o low while busy.
module rec_bank_tlb_mp #(
  parameter  int PAGE_NUM  = 2,
  parameter  int BANK_NUM  = 4,
  parameter  int LCU_8X8_W = 3,
  localparam int BANK_W    = $clog2(BANK_NUM),
  localparam int PAGE_W    = (PAGE_NUM > 2) ? $clog2(PAGE_NUM) : 1,
  localparam int AW        = 2 * LCU_8X8_W,
  localparam int ENT       = 1 << AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   cover_valid_i,
  output logic                   cover_ready_o,
  input  logic [LCU_8X8_W-1:0]   cover_x_i,
  input  logic [LCU_8X8_W-1:0]   cover_y_i,
  input  logic [2:0]             cover_size_i,
  output logic                   cover_done_o,
  input  logic                   pre_type_i,
  input  logic                   pre_sel_i,
  input  logic [LCU_8X8_W-1:0]   pre_x_i,
  input  logic [LCU_8X8_W-1:0]   pre_y_i,
  output logic [4*BANK_W-1:0]    pre_bank_o,
  output logic [PAGE_W-1:0]      pre_cbank_o,
  input  logic [AW+2:0]          ec_addr_i,
  output logic [BANK_W-1:0]      ec_bank_o,
  output logic [PAGE_W-1:0]      ec_cbank_o
);

  typedef enum logic [1:0] {S_IDLE, S_COVER, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [PAGE_W-1:0]   cur_page_q, ec_page;
  logic [PAGE_W-1:0]   tgt_page_q, tgt_page_d;
  logic [AW-1:0]       base_q, base_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       len_m1_q, len_m1_d;
  logic [BANK_W-1:0]   tbl_q [PAGE_NUM][ENT];
  logic [4*BANK_W-1:0] pre_bank_q, pre_bank_d;
  logic [BANK_W-1:0]   ec_bank_q, ec_bank_d;

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [BANK_W-1:0]   new_bank;
  logic                found, taken;

  logic [LCU_8X8_W-1:0] pre_x1, pre_y1;
  logic [AW-1:0]        a_tl, a_tr, a_bl, a_br, ec_idx;
  logic [1:0]           unused_ec_lsb;

  function automatic logic [AW-1:0] morton(input logic [LCU_8X8_W-1:0] x,
                                           input logic [LCU_8X8_W-1:0] y);
    logic [AW-1:0] m;
    m = '0;
    for (int i = 0; i < LCU_8X8_W; i++) begin
      m[2*i]   = x[i];
      m[2*i+1] = y[i];
    end
    return m;
  endfunction

  // Sizes of 8x8 and below occupy one entry; anything past the LCU clamps to the whole table.
  function automatic logic [AW-1:0] len_m1_of(input logic [2:0] sz);
    int s;
    if (sz <= 3'd1) return '0;
    s = int'(sz) - 1;
    if (s >= LCU_8X8_W) return AW'(ENT - 1);
    return AW'((1 << (2 * s)) - 1);
  endfunction

  assign ec_page       = (cur_page_q == '0) ? PAGE_W'(PAGE_NUM - 1) : cur_page_q - PAGE_W'(1);
  assign pre_cbank_o   = cur_page_q;
  assign ec_cbank_o    = ec_page;
  assign cover_ready_o = (state_q == S_IDLE);
  assign cover_done_o  = (state_q == S_DONE);
  assign pre_bank_o    = pre_bank_q;
  assign ec_bank_o     = ec_bank_q;

  assign wr_en   = (state_q == S_COVER);
  assign wr_addr = base_q + cnt_q;

  // Lowest non-chroma bank not referenced by any page at this entry.
  always_comb begin
    new_bank = '0;
    found    = 1'b0;
    taken    = 1'b0;
    for (int b = 0; b < BANK_NUM - 1; b++) begin
      taken = 1'b0;
      for (int p = 0; p < PAGE_NUM; p++) begin
        if (tbl_q[p][wr_addr] == BANK_W'(b)) taken = 1'b1;
      end
      if (!taken && !found) begin
        new_bank = BANK_W'(b);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    tgt_page_d = tgt_page_q;
    len_m1_d   = len_m1_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cover_valid_i) begin
          state_d    = S_COVER;
          base_d     = morton(cover_x_i, cover_y_i);
          tgt_page_d = cur_page_q;
          len_m1_d   = len_m1_of(cover_size_i);
          cnt_d      = '0;
        end
      end
      S_COVER: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == len_m1_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pre_x1        = pre_x_i + LCU_8X8_W'(1);
  assign pre_y1        = pre_y_i + LCU_8X8_W'(1);
  assign a_tl          = morton(pre_x_i, pre_y_i);
  assign a_tr          = morton(pre_x1,  pre_y_i);
  assign a_bl          = morton(pre_x_i, pre_y1);
  assign a_br          = morton(pre_x1,  pre_y1);
  assign ec_idx        = ec_addr_i[AW+1:2];
  assign unused_ec_lsb = ec_addr_i[1:0];

  always_comb begin
    pre_bank_d = {tbl_q[cur_page_q][a_br], tbl_q[cur_page_q][a_bl],
                  tbl_q[cur_page_q][a_tr], tbl_q[cur_page_q][a_tl]};
    if (pre_sel_i)       pre_bank_d = {4{BANK_W'(BANK_NUM - 1)}};
    else if (pre_type_i) pre_bank_d = {4{BANK_W'(cur_page_q)}};
  end

  // ec shares the intra/inter select with pre.
  always_comb begin
    ec_bank_d = tbl_q[ec_page][ec_idx];
    if (ec_addr_i[AW+2]) ec_bank_d = BANK_W'(BANK_NUM - 1);
    else if (pre_type_i) ec_bank_d = BANK_W'(ec_page);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_page_q <= '0;
      tgt_page_q <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      len_m1_q   <= '0;
      pre_bank_q <= '0;
      ec_bank_q  <= '0;
      for (int p = 0; p < PAGE_NUM; p++) begin
        for (int e = 0; e < ENT; e++) tbl_q[p][e] <= BANK_W'(p);
      end
    end else begin
      state_q    <= state_d;
      tgt_page_q <= tgt_page_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      len_m1_q   <= len_m1_d;
      pre_bank_q <= pre_bank_d;
      ec_bank_q  <= ec_bank_d;
      if (start_i)
        cur_page_q <= (cur_page_q == PAGE_W'(PAGE_NUM - 1)) ? '0 : cur_page_q + PAGE_W'(1);
      if (wr_en) tbl_q[tgt_page_q][wr_addr] <= new_bank;
    end
  end

endmodule

// File: tb/tb_rec_bank_tlb_mp.sv
// Directed bench for rec_bank_tlb_mp: 2-page/4-bank and 3-page/5-bank instances share one stimulus stream.
module tb_rec_bank_tlb_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, cover_valid_i, pre_type_i, pre_sel_i;
  logic [2:0]  cover_x_i, cover_y_i, cover_size_i, pre_x_i, pre_y_i;
  logic [8:0]  ec_addr_i;

  logic        a_ready, a_done, b_ready, b_done;
  logic [7:0]  a_pre;
  logic [11:0] b_pre;
  logic [0:0]  a_pcb, a_ecb;
  logic [1:0]  b_pcb, b_ecb;
  logic [1:0]  a_ec;
  logic [2:0]  b_ec;

  always #5 clk = ~clk;

  rec_bank_tlb_mp #(.PAGE_NUM(2), .BANK_NUM(4), .LCU_8X8_W(3)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .cover_valid_i(cover_valid_i), .cover_ready_o(a_ready),
    .cover_x_i(cover_x_i), .cover_y_i(cover_y_i), .cover_size_i(cover_size_i),
    .cover_done_o(a_done), .pre_type_i(pre_type_i), .pre_sel_i(pre_sel_i),
    .pre_x_i(pre_x_i), .pre_y_i(pre_y_i), .pre_bank_o(a_pre), .pre_cbank_o(a_pcb),
    .ec_addr_i(ec_addr_i), .ec_bank_o(a_ec), .ec_cbank_o(a_ecb));

  rec_bank_tlb_mp #(.PAGE_NUM(3), .BANK_NUM(5), .LCU_8X8_W(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start_i),
    .cover_valid_i(cover_valid_i), .cover_ready_o(b_ready),
    .cover_x_i(cover_x_i), .cover_y_i(cover_y_i), .cover_size_i(cover_size_i),
    .cover_done_o(b_done), .pre_type_i(pre_type_i), .pre_sel_i(pre_sel_i),
    .pre_x_i(pre_x_i), .pre_y_i(pre_y_i), .pre_bank_o(b_pre), .pre_cbank_o(b_pcb),
    .ec_addr_i(ec_addr_i), .ec_bank_o(b_ec), .ec_cbank_o(b_ecb));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference table: index 0 = 2-page instance, index 1 = 3-page instance.
  int np [2] = '{2, 3};
  int nb [2] = '{4, 5};
  int cur [2];
  int mdl [2][3][64];

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  function automatic int mort(int x, int y);
    int m = 0;
    for (int i = 0; i < 3; i++) begin
      m |= ((x >> i) & 1) << (2 * i);
      m |= ((y >> i) & 1) << (2 * i + 1);
    end
    return m;
  endfunction

  function automatic int ecp(int d);
    return (cur[d] == 0) ? np[d] - 1 : cur[d] - 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cur[d] = 0;
      for (int p = 0; p < 3; p++)
        for (int e = 0; e < 64; e++) mdl[d][p][e] = p;
    end
  endtask

  task automatic model_start();
    for (int d = 0; d < 2; d++) cur[d] = (cur[d] == np[d] - 1) ? 0 : cur[d] + 1;
  endtask

  task automatic model_cover(int x, int y, int size);
    int len, base, a, t;
    bit used, done;
    len  = (size <= 1) ? 1 : (size == 2) ? 4 : (size == 3) ? 16 : 64;
    base = mort(x, y);
    for (int d = 0; d < 2; d++) begin
      t = cur[d];
      for (int c = 0; c < len; c++) begin
        a    = (base + c) % 64;
        done = 1'b0;
        for (int b = 0; b <= nb[d] - 2; b++) begin
          used = 1'b0;
          for (int p = 0; p < np[d]; p++) if (mdl[d][p][a] == b) used = 1'b1;
          if (!used && !done) begin
            mdl[d][t][a] = b;
            done = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_pre(int d, int sel, int typ, int x, int y);
    int bw, v;
    int a [4];
    logic [31:0] r;
    bw   = (d == 0) ? 2 : 3;
    r    = '0;
    a[0] = mort(x, y);
    a[1] = mort((x + 1) % 8, y);
    a[2] = mort(x, (y + 1) % 8);
    a[3] = mort((x + 1) % 8, (y + 1) % 8);
    for (int k = 0; k < 4; k++) begin
      if (sel != 0)      v = nb[d] - 1;
      else if (typ != 0) v = cur[d];
      else               v = mdl[d][cur[d]][a[k]];
      r = r | (32'(v) << (k * bw));
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_ec(int d, int ch, int typ, int idx);
    if (ch != 0)  return 32'(nb[d] - 1);
    if (typ != 0) return 32'(ecp(d));
    return 32'(mdl[d][ecp(d)][idx]);
  endfunction

  function automatic logic [31:0] obs(int src);
    case (src)
      0:       return 32'(a_pre);
      1:       return 32'(a_ec);
      2:       return 32'(b_pre);
      default: return 32'(b_ec);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push(string tag, int src, logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.src = src;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic lookup(string tag, int sel, int typ, int x, int y, int ch, int idx);
    sb_t s;
    @(negedge clk);
    pre_sel_i  = sel[0];
    pre_type_i = typ[0];
    pre_x_i    = x[2:0];
    pre_y_i    = y[2:0];
    ec_addr_i  = {ch[0], idx[5:0], 2'b00};
    push({tag, "/pre2"}, 0, exp_pre(0, sel, typ, x, y));
    push({tag, "/ec2"},  1, exp_ec(0, ch, typ, idx));
    push({tag, "/pre3"}, 2, exp_pre(1, sel, typ, x, y));
    push({tag, "/ec3"},  3, exp_ec(1, ch, typ, idx));
    @(negedge clk);
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      check(s.tag, obs(s.src), s.exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    model_start();
    @(negedge clk);
    start_i = 1'b0;
    check("start/pcb2", 32'(a_pcb), 32'(cur[0]));
    check("start/ecb2", 32'(a_ecb), 32'(ecp(0)));
    check("start/pcb3", 32'(b_pcb), 32'(cur[1]));
    check("start/ecb3", 32'(b_ecb), 32'(ecp(1)));
  endtask

  task automatic do_cover(string tag, int x, int y, int size, bit mid_start, int len);
    int low, dn_a, dn_b, cyc;
    @(negedge clk);
    check({tag, "/rdy_before"}, 32'(a_ready), 32'd1);
    cover_valid_i = 1'b1;
    cover_x_i     = x[2:0];
    cover_y_i     = y[2:0];
    cover_size_i  = size[2:0];
    model_cover(x, y, size);
    @(negedge clk);
    cover_valid_i = 1'b0;
    low = 0; dn_a = 0; dn_b = 0; cyc = 0;
    while (a_ready !== 1'b1 && cyc < 300) begin
      low++;
      if (a_done === 1'b1) dn_a++;
      if (b_done === 1'b1) dn_b++;
      if (mid_start && cyc == 2) begin
        start_i = 1'b1;
        model_start();
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    check({tag, "/busy_cycles"}, 32'(low), 32'(len + 1));
    check({tag, "/done_pulses2"}, 32'(dn_a), 32'd1);
    check({tag, "/done_pulses3"}, 32'(dn_b), 32'd1);
    check({tag, "/rdy_after3"}, 32'(b_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; cover_valid_i = 1'b0;
    cover_x_i = '0; cover_y_i = '0; cover_size_i = '0;
    pre_type_i = 1'b0; pre_sel_i = 1'b0; pre_x_i = '0; pre_y_i = '0; ec_addr_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst/ready", 32'(a_ready), 32'd1);
    check("rst/done",  32'(a_done),  32'd0);
    check("rst/pre",   32'(a_pre),   32'd0);
    check("rst/ec",    32'(a_ec),    32'd0);
    check("rst/pcb",   32'(a_pcb),   32'd0);
    check("rst/ecb2",  32'(a_ecb),   32'd1);
    check("rst/ecb3",  32'(b_ecb),   32'd2);
    lookup("rst_lookup", 0, 0, 0, 0, 0, 0);

    // 16x16 at (2,2): entries 12..15 of page 0
    do_cover("c16", 2, 2, 2, 1'b0, 4);
    lookup("c16_pre22", 0, 0, 2, 2, 0, 12);
    check("c16/pre22_literal", 32'(a_pre), 32'haa);

    pulse_start();
    do_cover("c8", 2, 2, 1, 1'b0, 1);
    pulse_start();
    lookup("c8_ec48", 0, 0, 2, 2, 0, 12);
    check("c8/ec48_literal", 32'(a_ec), 32'd0);

    // 32x32 with a page rotation mid-cover
    do_cover("c32mid", 0, 0, 3, 1'b1, 16);
    check("c32mid/pcb2", 32'(a_pcb), 32'(cur[0]));
    check("c32mid/pcb3", 32'(b_pcb), 32'(cur[1]));
    for (int i = 0; i < 17; i++) lookup($sformatf("c32mid_sweep%0d", i), 0, 0, i % 8, i / 8, 0, i);

    lookup("chroma", 1, 0, 3, 4, 1, 5);
    check("chroma/pre_literal", 32'(a_pre), 32'hff);
    lookup("inter", 0, 1, 5, 6, 0, 7);

    // Full-LCU cover, then view the written page through ec
    do_cover("c64", 0, 0, 4, 1'b0, 64);
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      lookup($sformatf("c64_sweep%0d", i), 0, 0, i % 8, i / 8, 0, i);
      for (int p = 0; p < 3; p++) begin
        if (p != ecp(1)) begin
          n_assert++;
          assert (32'(b_ec) !== 32'(mdl[1][p][i])) else begin
            n_fail++;
            $error("FAIL c64_distinct%0d_p%0d: observed %0h expected a value other than %0h",
                   i, p, b_ec, mdl[1][p][i]);
          end
        end
      end
    end
    lookup("wrap77", 0, 0, 7, 7, 0, 63);

    do_cover("clamp", 0, 0, 7, 1'b0, 64);
    lookup("clamp_pre", 0, 0, 1, 6, 0, 33);

    // Reset in the middle of a cover abandons it
    @(negedge clk);
    cover_valid_i = 1'b1; cover_x_i = '0; cover_y_i = '0; cover_size_i = 3'd4;
    @(negedge clk);
    cover_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst/ready", 32'(a_ready), 32'd1);
    check("midrst/done",  32'(a_done),  32'd0);
    check("midrst/pcb",   32'(a_pcb),   32'd0);
    lookup("midrst_lookup", 0, 0, 2, 2, 0, 12);
    lookup("midrst_lookup0", 0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
